mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 12, RAM address width
- MEM_BLOCKS, 4096, RAM depth in words
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset:
- sys_clk  in  1  single clock, all state on rising edge
- sys_rst  in  1  asynchronous active-high reset
REQ-003 Control ports SHALL be:
- start  in  1  load request, sampled only in IDLE
- abort  in  1  cancel current load
- base_addr  in  ADDR_WIDTH  first RAM word address, sampled at start
- word_count  in  ADDR_WIDTH+1  words to load (0..MEM_BLOCKS), sampled at start
REQ-004 Byte-stream ports SHALL be:
- s_valid  in  1  byte available
- s_data  in  8  byte value
- s_ready  out  1  loader accepts a byte
REQ-005 RAM write-port ports SHALL be:
- wen  out  1  write strobe
- w_addr  out  ADDR_WIDTH  write address
- w_data  out  DATA_WIDTH  write word
REQ-006 Status ports SHALL be:
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- checksum  out  32  wrapping sum of words written in current/last load

Function
REQ-007 The FSM SHALL have states IDLE, RECV, WRITE, DONE.
REQ-008 IDLE: on start=1 and word_count=0, go to DONE; on start=1 and word_count>0, go to RECV, latch base_addr/word_count, clear byte index, word index, and checksum; otherwise stay.
REQ-009 start SHALL be ignored in every state other than IDLE.
REQ-010 s_ready SHALL be 1 only in RECV; a byte SHALL transfer only on a cycle with s_valid=1 and s_ready=1.
REQ-011 Byte k (k=0..3) of each word SHALL land in w_data bits [8k+7:8k], making the word little-endian.
REQ-012 Idle cycles (s_valid=0) in RECV SHALL hold all state.
REQ-013 The 4th byte transfer SHALL move the FSM to WRITE.
REQ-014 WRITE SHALL last exactly one cycle, with:
- wen=1
- w_addr=(base+word index) mod MEM_BLOCKS
- w_data=assembled word
- checksum updated with the word
REQ-015 The cycle after WRITE: go to DONE if the incremented word index equals word_count, else go to RECV with the byte index cleared.
REQ-016 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-017 wen SHALL be 0 in IDLE, RECV and DONE; w_addr and w_data SHALL hold their last values when wen=0.
REQ-018 Address SHALL wrap from MEM_BLOCKS-1 to 0 with no error.
REQ-019 abort=1 in RECV or DONE SHALL force IDLE next cycle, with no wen and no done pulse; a partially assembled word SHALL be discarded.
REQ-020 abort=1 in WRITE SHALL let that write complete, then go to IDLE with no done pulse.
REQ-021 abort SHALL take priority over start in IDLE (neither acts when both are 1).
REQ-022 checksum SHALL be a 32-bit modulo-2^32 sum of the written words and SHALL hold its value in IDLE until the next accepted start.
REQ-023 The design SHALL not depend on s_data while s_valid=0.

Reset
REQ-024 Asserting sys_rst SHALL immediately force the state to IDLE and all outputs to 0, including s_ready, wen, w_addr, w_data, busy, done and checksum.
REQ-025 Reset asserted mid-load SHALL discard all progress; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-026 base_addr=0x010, word_count=2, bytes 11 22 33 44 55 66 77 88 back-to-back -> required response:
- wen at 0x010 with 0x44332211
- wen at 0x011 with 0x88776655
- done one cycle after the second wen
- checksum=0xCCAA8866
REQ-027 base_addr=0xFFF, word_count=2 -> writes to 0xFFF then 0x000.
REQ-028 Same bytes as REQ-026 with random s_valid gaps -> identical writes and checksum; exactly 2 wen pulses.
REQ-029 word_count=0 with start -> busy for one cycle (DONE), done pulse, no wen.
REQ-030 abort after 2 bytes, then a new start with word_count=1 and bytes AA BB CC DD -> no wen and no done for the aborted load, then a single write of 0xDDCCBBAA and one done pulse.
REQ-031 sys_rst pulse during RECV -> outputs 0 in the same cycle, no subsequent wen, busy=0.

Source files
------------

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Assembles a little-endian stream of bytes into RAM words and writes them to
// consecutive RAM addresses starting at a base address. The address wraps
// modulo MEM_BLOCKS. A running 32-bit checksum of the written words is kept
// for the current or most recent load.
//
// Ports
//   sys_clk     : single clock, all state on the rising edge
//   sys_rst     : asynchronous active-high reset
//   start       : load request, only looked at while idle
//   abort       : cancel the current load
//   base_addr   : first RAM word address, captured at start
//   word_count  : number of words to load (0..MEM_BLOCKS), captured at start
//   s_valid     : a byte is offered on s_data
//   s_data      : byte value
//   s_ready     : loader accepts a byte this cycle
//   wen         : RAM write strobe
//   w_addr      : RAM write address (holds when wen=0)
//   w_data      : RAM write word (holds when wen=0)
//   busy        : loader is not idle
//   done        : one-cycle completion pulse
//   checksum    : modulo-2^32 sum of the words written by the load
// -----------------------------------------------------------------------------
module mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BLOCKS = 4096
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0]     LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [BIDX_W-1:0]       byteIdx_q;
  logic [ADDR_WIDTH:0]     wordIdx_q;
  logic [ADDR_WIDTH:0]     wordCount_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic                    sReady_q;
  logic                    wen_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   wAddr_q;
  logic [DATA_WIDTH-1:0]   wData_q;
  logic [31:0]             checksum_q;

  logic [DATA_WIDTH-1:0]   asm_d;
  logic [ADDR_WIDTH:0]     wordIdxInc_d;

  // The word as it will look once the byte on s_data is merged into its
  // little-endian lane; used both to update the assembly register and to
  // launch the write directly when this is the last byte of the word.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byteIdx_q, 3'b000} +: 8] = s_data;
    wordIdxInc_d = wordIdx_q + (ADDR_WIDTH+1)'(1);
  end

  // Loader FSM. Outputs are registered alongside the state so each one is
  // valid for exactly the cycles its state lasts. addr_q runs alongside
  // wordIdx_q and wraps itself, so no modulo arithmetic is needed.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      byteIdx_q   <= '0;
      wordIdx_q   <= '0;
      wordCount_q <= '0;
      addr_q      <= '0;
      asm_q       <= '0;
      sReady_q    <= 1'b0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wAddr_q     <= '0;
      wData_q     <= '0;
      checksum_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // abort wins over start; checksum is left alone for an empty load
          if (start && !abort) begin
            busy_q <= 1'b1;
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= RECV;
              addr_q      <= base_addr;
              wordCount_q <= word_count;
              byteIdx_q   <= '0;
              wordIdx_q   <= '0;
              checksum_q  <= '0;
              sReady_q    <= 1'b1;
            end
          end
        end

        RECV: begin
          if (abort) begin
            state_q  <= IDLE;
            sReady_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (s_valid) begin
            asm_q <= asm_d;
            if (byteIdx_q == LAST_BYTE) begin
              state_q    <= WRITE;
              sReady_q   <= 1'b0;
              wen_q      <= 1'b1;
              wAddr_q    <= addr_q;
              wData_q    <= asm_d;
              checksum_q <= checksum_q + 32'(asm_d);
            end else begin
              byteIdx_q <= byteIdx_q + BIDX_W'(1);
            end
          end
        end

        WRITE: begin
          // the write in progress always completes, even under abort
          wen_q     <= 1'b0;
          wordIdx_q <= wordIdxInc_d;
          addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wordIdxInc_d == wordCount_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= RECV;
            byteIdx_q <= '0;
            sReady_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q  <= IDLE;
          sReady_q <= 1'b0;
          wen_q    <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready  = sReady_q;
  assign wen      = wen_q;
  assign w_addr   = wAddr_q;
  assign w_data   = wData_q;
  assign busy     = busy_q;
  assign checksum = checksum_q;
  // An abort seen during the DONE cycle cancels the completion pulse.
  assign done     = done_q & ~abort;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//
// Self-checking bench for mem_loader: a table of directed loads with known
// results, hand-written sequences for abort/reset/idle corner cases, and
// randomized loads compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_mem_loader;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 4096;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic          wen;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          busy;
  logic          done;
  logic [31:0]   checksum;

  mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_BLOCKS(MB)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .word_count(word_count),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wen       (wen),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] gotAddr[$];
  logic [DW-1:0] gotData[$];
  int            doneCnt = 0;
  int            doneCyc = -1;
  int            lastWenCyc = -1;

  logic [7:0]    txBytes[$];
  logic [AW-1:0] expAddr[$];
  logic [DW-1:0] expData[$];
  int            expDone;
  logic [31:0]   expSum;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic [63:0]   bytes;
    int            nExp;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic [31:0]   sum;
  } vec_t;

  vec_t vecs[4];

  // Cycle counter used to relate done pulses to the last write.
  always @(posedge sys_clk) cyc++;

  // Observe the write port and done at the falling edge, well away from the
  // edge where the DUT updates.
  always @(negedge sys_clk) begin
    if (wen === 1'b1) begin
      gotAddr.push_back(w_addr);
      gotData.push_back(w_data);
      lastWenCyc = cyc;
    end
    if (done === 1'b1) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clearMon;
    gotAddr.delete();
    gotData.delete();
    doneCnt = 0;
    doneCyc = -1;
    lastWenCyc = -1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  // Reference model: which words a load must write, where, and the checksum,
  // derived from the byte list alone. An abort after k bytes keeps only the
  // k/4 words that were complete.
  task automatic modelLoad(input logic [AW-1:0] base, input int cnt, input int abortAfter);
    int nWords;
    logic [31:0] d;
    expAddr.delete();
    expData.delete();
    expSum = '0;
    nWords = (abortAfter < 0) ? cnt : abortAfter / 4;
    for (int i = 0; i < nWords; i++) begin
      d = {txBytes[4*i+3], txBytes[4*i+2], txBytes[4*i+1], txBytes[4*i]};
      expAddr.push_back(AW'((int'(base) + i) % MB));
      expData.push_back(d);
      expSum = expSum + d;
    end
    expDone = (abortAfter < 0) ? 1 : 0;
  endtask

  // Runs one load: start, stream txBytes with optional gaps, optional abort
  // after abortAfter accepted bytes, then wait for the loader to go idle.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] cnt,
                               input int gapPct, input int abortAfter);
    int sent;
    int guard;
    int w;
    clearMon();
    start      = 1'b1;
    base_addr  = base;
    word_count = cnt;
    tick();
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = (AW+1)'($urandom);
    sent  = 0;
    guard = 0;
    while (sent < txBytes.size() && !(abortAfter >= 0 && sent == abortAfter) && guard < 5000) begin
      if ($urandom_range(0, 99) < gapPct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = txBytes[sent];
        if (s_ready) sent++;
      end
      tick();
      guard++;
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    checkOutput("stream timeout", (guard >= 5000) ? 64'd1 : 64'd0, 64'd0);
    if (abortAfter >= 0) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    w = 0;
    while (busy && w < 50) begin
      tick();
      w++;
    end
    checkOutput("idle after load", busy, 0);
    tick();
    tick();
  endtask

  task automatic checkLoad(input string name);
    checkOutput({name, " wen count"}, gotAddr.size(), expAddr.size());
    for (int i = 0; i < expAddr.size(); i++) begin
      if (i < gotAddr.size()) begin
        checkOutput($sformatf("%s addr[%0d]", name, i), gotAddr[i], expAddr[i]);
        checkOutput($sformatf("%s data[%0d]", name, i), gotData[i], expData[i]);
      end
    end
    checkOutput({name, " done count"}, doneCnt, expDone);
    if (expDone == 1 && expAddr.size() > 0)
      checkOutput({name, " done timing"}, doneCyc, lastWenCyc + 1);
    checkOutput({name, " checksum"}, checksum, expSum);
  endtask

  task automatic loadVec(input int v, input int gapPct);
    txBytes.delete();
    for (int k = 0; k < int'(vecs[v].count) * 4; k++)
      txBytes.push_back(vecs[v].bytes[8*k +: 8]);
    applyStimulus(vecs[v].base, vecs[v].count, gapPct, -1);
    expAddr.delete();
    expData.delete();
    expAddr.push_back(vecs[v].addr0);
    expData.push_back(vecs[v].data0);
    if (vecs[v].nExp > 1) begin
      expAddr.push_back(vecs[v].addr1);
      expData.push_back(vecs[v].data1);
    end
    expSum  = vecs[v].sum;
    expDone = 1;
  endtask

  initial begin
    logic [31:0] prevSum;
    logic [AW-1:0] rBase;
    int rCnt;
    int rAbort;

    vecs[0] = '{12'h010, 13'd2, 64'h8877665544332211, 2, 12'h010, 32'h44332211, 12'h011, 32'h88776655, 32'hCCAA8866};
    vecs[1] = '{12'hFFF, 13'd2, 64'h0807060504030201, 2, 12'hFFF, 32'h04030201, 12'h000, 32'h08070605, 32'h0C0A0806};
    vecs[2] = '{12'h123, 13'd1, 64'h00000000DDCCBBAA, 1, 12'h123, 32'hDDCCBBAA, 12'h000, 32'h0, 32'hDDCCBBAA};
    vecs[3] = '{12'h7FE, 13'd2, 64'hFFFFFFFFFFFFFFFF, 2, 12'h7FE, 32'hFFFFFFFF, 12'h7FF, 32'hFFFFFFFF, 32'hFFFFFFFE};

    // Reset state
    repeat (3) tick();
    checkOutput("reset s_ready", s_ready, 0);
    checkOutput("reset wen", wen, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset checksum", checksum, 0);
    sys_rst = 1'b0;
    tick();

    // Table-driven loads, back-to-back bytes
    for (int v = 0; v < 4; v++) begin
      loadVec(v, 0);
      checkLoad($sformatf("vec%0d", v));
    end

    // Same data as the first vector with random s_valid gaps
    loadVec(0, 40);
    checkLoad("gapped vec0");
    prevSum = expSum;

    // Empty load: one busy cycle in DONE with a done pulse and no write
    clearMon();
    start = 1'b1;
    word_count = '0;
    base_addr = 12'h0AB;
    tick();
    start = 1'b0;
    checkOutput("zero busy", busy, 1);
    checkOutput("zero done", done, 1);
    tick();
    checkOutput("zero busy after", busy, 0);
    checkOutput("zero done after", done, 0);
    tick();
    checkOutput("zero wen count", gotAddr.size(), 0);
    checkOutput("zero done count", doneCnt, 1);
    checkOutput("zero checksum hold", checksum, prevSum);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    word_count = 13'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort prio busy", busy, 0);
    checkOutput("abort prio s_ready", s_ready, 0);
    tick();

    // Abort mid-word, then a fresh single-word load
    txBytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(12'h050, 13'd1, 0, 2);
    modelLoad(12'h050, 1, 2);
    checkLoad("aborted load");
    txBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(12'h051, 13'd1, 0, -1);
    expAddr = '{12'h051};
    expData = '{32'hDDCCBBAA};
    expSum  = 32'hDDCCBBAA;
    expDone = 1;
    checkLoad("after abort");

    // Abort during WRITE: the write lands, no done
    clearMon();
    start = 1'b1;
    base_addr = 12'h040;
    word_count = 13'd2;
    tick();
    start = 1'b0;
    sendByte(8'h10);
    sendByte(8'h20);
    sendByte(8'h30);
    sendByte(8'h40);
    checkOutput("write wen", wen, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("write abort busy", busy, 0);
    tick();
    tick();
    checkOutput("write abort wen count", gotAddr.size(), 1);
    if (gotData.size() > 0) checkOutput("write abort data", gotData[0], 32'h40302010);
    checkOutput("write abort done count", doneCnt, 0);
    checkOutput("write abort checksum", checksum, 32'h40302010);

    // Abort in DONE suppresses the pulse
    clearMon();
    start = 1'b1;
    word_count = '0;
    tick();
    start = 1'b0;
    abort = 1'b1;
    #1;
    checkOutput("done abort pulse", done, 0);
    tick();
    abort = 1'b0;
    checkOutput("done abort busy", busy, 0);
    tick();
    checkOutput("done abort count", doneCnt, 0);

    // start is ignored once a load is running
    clearMon();
    start = 1'b1;
    base_addr = 12'h300;
    word_count = 13'd1;
    tick();
    base_addr = 12'h555;
    word_count = '0;
    tick();
    checkOutput("busy start s_ready", s_ready, 1);
    checkOutput("busy start busy", busy, 1);
    sendByte(8'h01);
    sendByte(8'h02);
    sendByte(8'h03);
    sendByte(8'h04);
    start = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("busy start wen count", gotAddr.size(), 1);
    if (gotAddr.size() > 0) checkOutput("busy start addr", gotAddr[0], 12'h300);
    if (gotData.size() > 0) checkOutput("busy start data", gotData[0], 32'h04030201);
    checkOutput("busy start done count", doneCnt, 1);

    // Reset pulse in RECV clears everything at once
    clearMon();
    start = 1'b1;
    base_addr = 12'h100;
    word_count = 13'd2;
    tick();
    start = 1'b0;
    sendByte(8'h5A);
    sendByte(8'hA5);
    #2;
    sys_rst = 1'b1;
    #1;
    checkOutput("rst s_ready", s_ready, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst wen", wen, 0);
    checkOutput("rst w_addr", w_addr, 0);
    checkOutput("rst w_data", w_data, 0);
    checkOutput("rst checksum", checksum, 0);
    checkOutput("rst done", done, 0);
    tick();
    sys_rst = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'($urandom);
      tick();
    end
    s_valid = 1'b0;
    checkOutput("post rst wen count", gotAddr.size(), 0);
    checkOutput("post rst busy", busy, 0);

    // Randomized loads against the model
    for (int n = 0; n < 25; n++) begin
      rBase = ($urandom_range(0, 3) == 0) ? AW'(MB - 2) : AW'($urandom);
      rCnt  = $urandom_range(1, 4);
      txBytes.delete();
      for (int k = 0; k < rCnt * 4; k++) txBytes.push_back(8'($urandom));
      rAbort = -1;
      if ($urandom_range(0, 3) == 0)
        rAbort = 4 * $urandom_range(0, rCnt - 1) + $urandom_range(1, 3);
      modelLoad(rBase, rCnt, rAbort);
      applyStimulus(rBase, (AW+1)'(rCnt), 30, rAbort);
      checkLoad($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
